uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter byte sink among NUM_PORTS byte-stream requesters.
- Each requester offers packets as ready/valid bytes with a last flag.
- Grants are round-robin and held for a whole packet, so bytes from different requesters never interleave on the serial line.
- Sits between on-chip producers (console, status reporter, echo path) and the uart_transmitter data_in/data_in_valid/data_in_ready interface.

Parameters:
- NUM_PORTS, 4: number of requesters, 2..8.
- MAX_PKT_LEN, 16: maximum bytes per grant. The grant is forcibly released after this many transfers even without last. Range 1..255.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- req_data  input  NUM_PORTS*8  byte from port i on bits [8i+7:8i]
- req_valid  input  NUM_PORTS  port i byte valid
- req_last  input  NUM_PORTS  port i byte is the final byte of its packet
- req_ready  output  NUM_PORTS  port i byte accepted this cycle when valid
- tx_data  output  8  byte to transmitter
- tx_valid  output  1  tx_data valid
- tx_ready  input  1  transmitter can accept a byte
- grant_id  output  $clog2(NUM_PORTS)  currently or last granted port
- busy  output  1  high whenever state is not IDLE

Behaviour:
- States: IDLE, STREAM (plus TAG when the optional feature is enabled). All are registered.
- Reset values: state=IDLE, grant_id=0, last_grant=NUM_PORTS-1 (so port 0 has top priority first), byte_cnt=0. Outputs: tx_valid=0, req_ready=0, busy=0.
- IDLE:
  - If any req_valid is high, pick the first valid port searching last_grant+1, last_grant+2, ... modulo NUM_PORTS.
  - Register it into grant_id, clear byte_cnt, and go to STREAM (or TAG) next cycle.
  - No byte is transferred in IDLE. Arbitration costs exactly one cycle.
- STREAM: combinational pass-through from the granted port.
  - tx_data = req_data[grant_id].
  - tx_valid = req_valid[grant_id].
  - req_ready[grant_id] = tx_ready. All other req_ready bits are 0.
- Transfer means tx_valid && tx_ready. On each transfer byte_cnt increments (8-bit).
- Release happens on a transfer where req_last[grant_id]=1 or byte_cnt==MAX_PKT_LEN-1. On release:
  - go to IDLE;
  - last_grant <= grant_id.
- The granted port dropping req_valid mid-packet does not release the grant. The arbiter waits indefinitely; there is no timeout.
- Minimum gap between packets is 1 cycle (the IDLE arbitration cycle). Back-to-back packets from the same port are allowed if it is the only requester.
- req_valid on non-granted ports is ignored until IDLE. Requesters must hold data/valid stable until ready (standard ready/valid).
- grant_id holds its value in IDLE.
- Reset asserted mid-packet returns to IDLE immediately. The partial packet is abandoned; no transfer occurs in the reset cycle.
- Throughput: one byte per cycle when tx_ready stays high.

Optional Feature:
- Macro: UART_TX_ARB_TAG_EN.
- When defined:
  - IDLE goes to TAG instead of STREAM.
  - In TAG: tx_valid=1, tx_data = 8'hF0 | grant_id (zero-extended), all req_ready=0.
  - On tx_ready, go to STREAM. The tag byte does not count toward byte_cnt.
  - A forced release at MAX_PKT_LEN re-tags on the next grant.
- When undefined: no TAG state or logic; IDLE goes directly to STREAM.

Test Plan:
- Reset, then port 2 sends 3 bytes 8'h41,8'h42,8'h43 (last on 8'h43) with tx_ready=1 -> grant_id=2; tx_data sequence 41,42,43 on three consecutive cycles; busy falls the cycle after 43; req_ready[0,1,3]=0 throughout.
- Ports 0 and 1 each hold a 2-byte packet valid from reset -> port 0 packet first, one IDLE cycle, then port 1 packet. Ports 0,1,3 valid afterward -> order 3 then 0 (round-robin from last_grant=1).
- Port 1 streams 20 bytes with no last, MAX_PKT_LEN=16, port 3 also valid -> exactly 16 bytes from port 1, then port 3 packet, then port 1 resumes at byte 17.
- Port 0 granted, tx_ready toggles 1,0,0,1 -> no byte repeated or dropped; req_ready[0] mirrors tx_ready; tx_data stable while tx_valid && !tx_ready.
- Reset asserted after 2 of 4 bytes of port 2 packet -> next cycle busy=0, tx_valid=0, grant_id=0; next arbitration gives port 0 priority.
- With UART_TX_ARB_TAG_EN, port 3 sends 8'h55 (last) -> tx bytes F3 then 55; without the macro -> only 55.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-atomic sharing of one UART tx byte sink; optional UART_TX_ARB_TAG_EN prefixes each grant with 8'hF0|grant_id.
// Latency: one arbitration cycle per grant, then combinational pass-through; backpressure: tx_ready drives only the granted req_ready.
module uart_tx_arbiter #(
  parameter int NUM_PORTS   = 4,
  parameter int MAX_PKT_LEN = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_PORTS*8-1:0]       req_data,
  input  logic [NUM_PORTS-1:0]         req_valid,
  input  logic [NUM_PORTS-1:0]         req_last,
  output logic [NUM_PORTS-1:0]         req_ready,
  output logic [7:0]                   tx_data,
  output logic                         tx_valid,
  input  logic                         tx_ready,
  output logic [$clog2(NUM_PORTS)-1:0] grant_id,
  output logic                         busy
);

  localparam int GW = $clog2(NUM_PORTS);

`ifdef UART_TX_ARB_TAG_EN
  typedef enum logic [1:0] {IDLE, STREAM, TAG} state_t;
`else
  typedef enum logic {IDLE, STREAM} state_t;
`endif

  state_t                 state, state_nxt;
  logic [GW-1:0]          grant_nxt;
  logic [GW-1:0]          last_grant, last_grant_nxt;
  logic [7:0]             byte_cnt, byte_cnt_nxt;
  logic [7:0]             port_data [NUM_PORTS];
  logic [2*NUM_PORTS-1:0] valid_dbl;
  logic [NUM_PORTS-1:0]   valid_rot;
  logic                   pick_vld;
  logic [GW-1:0]          pick_ofs;
  logic [GW-1:0]          pick_id;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port_data
    assign port_data[i] = req_data[8*i +: 8];
  end

  // Rotate so bit 0 is the port just after last_grant; the first set bit wins.
  assign valid_dbl = {req_valid, req_valid};
  assign valid_rot = NUM_PORTS'(valid_dbl >> (last_grant + 1'b1));

  always_comb begin
    pick_vld = 1'b0;
    pick_ofs = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (!pick_vld && valid_rot[k]) begin
        pick_vld = 1'b1;
        pick_ofs = GW'(k);
      end
    end
    pick_id = GW'((int'(last_grant) + 1 + int'(pick_ofs)) % NUM_PORTS);
  end

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant_id;
    last_grant_nxt = last_grant;
    byte_cnt_nxt   = byte_cnt;
    tx_valid       = 1'b0;
    tx_data        = port_data[grant_id];
    req_ready      = '0;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          grant_nxt    = pick_id;
          byte_cnt_nxt = '0;
`ifdef UART_TX_ARB_TAG_EN
          state_nxt    = TAG;
`else
          state_nxt    = STREAM;
`endif
        end
      end
      STREAM: begin
        tx_valid            = req_valid[grant_id];
        req_ready[grant_id] = tx_ready;
        if (tx_valid && tx_ready) begin
          byte_cnt_nxt = byte_cnt + 8'd1;
          // Forced release at MAX_PKT_LEN keeps one long packet from starving the others.
          if (req_last[grant_id] || (byte_cnt == 8'(MAX_PKT_LEN - 1))) begin
            state_nxt      = IDLE;
            last_grant_nxt = grant_id;
          end
        end
      end
`ifdef UART_TX_ARB_TAG_EN
      TAG: begin
        tx_valid = 1'b1;
        tx_data  = 8'hF0 | 8'(grant_id);
        if (tx_ready) begin
          state_nxt = STREAM;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
    // Nothing may transfer in a reset cycle, even mid-packet.
    if (reset) begin
      tx_valid  = 1'b0;
      req_ready = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      grant_id   <= '0;
      last_grant <= GW'(NUM_PORTS - 1);
      byte_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      grant_id   <= grant_nxt;
      last_grant <= last_grant_nxt;
      byte_cnt   <= byte_cnt_nxt;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus randomized traffic against a queue-based reference model.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

  localparam int NP   = 4;
  localparam int MAXL = 16;
`ifdef UART_TX_ARB_TAG_EN
  localparam bit TAG_EN = 1'b1;
`else
  localparam bit TAG_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic [NP*8-1:0] req_data;
  logic [NP-1:0]   req_valid;
  logic [NP-1:0]   req_last;
  logic [NP-1:0]   req_ready;
  logic [7:0]      tx_data;
  logic            tx_valid;
  logic            tx_ready;
  logic [1:0]      grant_id;
  logic            busy;

  uart_tx_arbiter #(.NUM_PORTS(NP), .MAX_PKT_LEN(MAXL)) dut (
    .clk(clk), .reset(reset),
    .req_data(req_data), .req_valid(req_valid), .req_last(req_last), .req_ready(req_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Producers: per-port byte queues {last, byte}; port_on = currently presenting the head.
  logic [8:0] port_q [NP][$];
  bit         port_on [NP];
  int         vld_pct = 100;
  int         rdy_pct = 100;
  bit         rdy_pat [$];

  // Reference model: grant bookkeeping expressed at packet level.
  bit m_busy, m_tag;
  int m_grant, m_last, m_cnt;
  logic [7:0] tx_log [$];
  logic [7:0] tag_log [$];
  int         grant_log [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_bytes(input string tag, input logic [7:0] got_q [$], input logic [7:0] exp_q [$]);
    chk({tag, "_len"}, got_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) chk(tag, got_q[k], exp_q[k]);
  endtask

  task automatic chk_ids(input string tag, input int got_q [$], input int exp_q [$]);
    chk({tag, "_len"}, got_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) chk(tag, got_q[k], exp_q[k]);
  endtask

  function automatic bit any_pending();
    for (int i = 0; i < NP; i++) if (port_q[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic add_pkt(input int p, input int len, input logic [7:0] base);
    for (int k = 0; k < len; k++) port_q[p].push_back({(k == len - 1), 8'(int'(base) + k)});
  endtask

  task automatic clear_logs();
    tx_log.delete();
    tag_log.delete();
    grant_log.delete();
  endtask

  task automatic drive();
    for (int i = 0; i < NP; i++) begin
      if (!port_on[i] && port_q[i].size() > 0 && $urandom_range(99) < vld_pct) port_on[i] = 1'b1;
      req_valid[i]       = port_on[i];
      req_data[8*i +: 8] = port_on[i] ? port_q[i][0][7:0] : 8'($urandom);
      req_last[i]        = port_on[i] ? port_q[i][0][8] : 1'b0;
    end
    if (rdy_pat.size() > 0) tx_ready = rdy_pat.pop_front();
    else tx_ready = ($urandom_range(99) < rdy_pct);
  endtask

  task automatic model_cycle();
    logic          exp_vld;
    logic [7:0]    exp_dat;
    logic [NP-1:0] exp_rdy;
    int            pk;
    exp_vld = 1'b0;
    exp_dat = 8'h00;
    exp_rdy = '0;
    if (!reset && m_busy) begin
      if (m_tag) begin
        exp_vld = 1'b1;
        exp_dat = 8'hF0 | 8'(m_grant);
      end else begin
        exp_vld = port_on[m_grant];
        if (exp_vld) exp_dat = port_q[m_grant][0][7:0];
        exp_rdy[m_grant] = tx_ready;
      end
    end
    chk("busy", busy, m_busy);
    chk("grant_id", grant_id, m_grant);
    chk("tx_valid", tx_valid, exp_vld);
    chk("req_ready", req_ready, exp_rdy);
    if (exp_vld) chk("tx_data", tx_data, exp_dat);

    if (reset) begin
      m_busy = 1'b0; m_tag = 1'b0; m_grant = 0; m_last = NP - 1; m_cnt = 0;
    end else if (!m_busy) begin
      pk = -1;
      for (int k = 1; k <= NP; k++) if (pk < 0 && port_on[(m_last + k) % NP]) pk = (m_last + k) % NP;
      if (pk >= 0) begin
        m_busy = 1'b1; m_grant = pk; m_cnt = 0; m_tag = TAG_EN;
        grant_log.push_back(pk);
      end
    end else if (m_tag) begin
      if (tx_ready) begin
        tag_log.push_back(exp_dat);
        m_tag = 1'b0;
      end
    end else if (exp_vld && tx_ready) begin
      tx_log.push_back(exp_dat);
      m_cnt++;
      if (port_q[m_grant][0][8] || m_cnt == MAXL) begin
        m_busy = 1'b0;
        m_last = m_grant;
      end
      port_q[m_grant].delete(0);
      port_on[m_grant] = 1'b0;
    end
  endtask

  task automatic step();
    drive();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) step();
    reset = 1'b0;
    clear_logs();
  endtask

  task automatic run_drain(input string tag, input int budget);
    int c;
    c = 0;
    while (c < budget && (m_busy || any_pending())) begin
      step();
      c++;
    end
    chk({tag, "_timeout"}, (c < budget), 1);
  endtask

  initial begin
    #500_000;
    $display("FAIL global_timeout: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1);
  end

  initial begin
    logic [7:0] eq [$];
    int         gq [$];
    int         c;

    reset = 1'b1; req_data = '0; req_valid = '0; req_last = '0; tx_ready = 1'b0;
    m_busy = 1'b0; m_tag = 1'b0; m_grant = 0; m_last = NP - 1; m_cnt = 0;
    for (int i = 0; i < NP; i++) port_on[i] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset(2);

    // Single 3-byte packet from port 2.
    add_pkt(2, 3, 8'h41);
    run_drain("s1", 50);
    gq = {2};
    chk_ids("s1_grants", grant_log, gq);
    eq = {8'h41, 8'h42, 8'h43};
    chk_bytes("s1_bytes", tx_log, eq);

    // Ports 0,1 from reset, then 0,1,3 round-robin from last_grant=1.
    reset = 1'b1;
    add_pkt(0, 2, 8'h00);
    add_pkt(1, 2, 8'h10);
    do_reset(2);
    run_drain("s2a", 50);
    add_pkt(0, 2, 8'h20);
    add_pkt(1, 2, 8'h30);
    add_pkt(3, 2, 8'h40);
    run_drain("s2b", 80);
    gq = {0, 1, 3, 0, 1};
    chk_ids("s2_grants", grant_log, gq);
    eq = {8'h00, 8'h01, 8'h10, 8'h11, 8'h40, 8'h41, 8'h20, 8'h21, 8'h30, 8'h31};
    chk_bytes("s2_bytes", tx_log, eq);

    // Long packet on port 1 is cut at MAX_PKT_LEN, port 3 slips in.
    reset = 1'b1;
    add_pkt(1, 20, 8'h60);
    add_pkt(3, 2, 8'hA0);
    do_reset(2);
    run_drain("s3", 120);
    gq = {1, 3, 1};
    chk_ids("s3_grants", grant_log, gq);
    eq.delete();
    for (int k = 0; k < 16; k++) eq.push_back(8'(8'h60 + k));
    eq.push_back(8'hA0);
    eq.push_back(8'hA1);
    for (int k = 16; k < 20; k++) eq.push_back(8'(8'h60 + k));
    chk_bytes("s3_bytes", tx_log, eq);

    // tx_ready backpressure pattern on port 0.
    do_reset(1);
    rdy_pat = {1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    add_pkt(0, 4, 8'hC0);
    run_drain("s4", 60);
    rdy_pat.delete();
    eq = {8'hC0, 8'hC1, 8'hC2, 8'hC3};
    chk_bytes("s4_bytes", tx_log, eq);

    // Reset mid-packet abandons port 2 and restores port 0 priority.
    do_reset(1);
    add_pkt(2, 4, 8'hD0);
    c = 0;
    while (c < 30 && tx_log.size() < 2) begin
      step();
      c++;
    end
    chk("s5_two_bytes_timeout", (c < 30), 1);
    add_pkt(0, 1, 8'hE0);
    do_reset(1);
    run_drain("s5", 60);
    gq = {0, 2};
    chk_ids("s5_grants", grant_log, gq);
    eq = {8'hE0, 8'hD2, 8'hD3};
    chk_bytes("s5_bytes", tx_log, eq);

    // Tag prefix (present only when the feature is built in).
    do_reset(1);
    add_pkt(3, 1, 8'h55);
    run_drain("s6", 30);
    eq = {8'h55};
    chk_bytes("s6_bytes", tx_log, eq);
    eq.delete();
    if (TAG_EN) eq.push_back(8'hF3);
    chk_bytes("s6_tags", tag_log, eq);

    // Randomized traffic with random valid gaps, backpressure and rare resets.
    do_reset(1);
    vld_pct = 60;
    rdy_pct = 70;
    for (int p = 0; p < NP; p++)
      for (int n = 0; n < 6; n++) add_pkt(p, $urandom_range(20, 1), 8'($urandom));
    c = 0;
    while (c < 20000 && (m_busy || any_pending())) begin
      reset = ($urandom_range(999) < 3);
      step();
      c++;
    end
    reset = 1'b0;
    run_drain("s7", 2000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
